// File: rtl/fcs_pkg.sv
// fcs_pkg: shared definitions for the FCS XOR-difference engine.
//   - fcs_state_e : engine state encoding (IDLE, ACCUM, EMIT)
//   - POLY_CRC32  : CRC32 generator polynomial (implicit x^32 term)
//   - INIT_CRC32  : CRC32 register reload value
package fcs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } fcs_state_e;

  localparam logic [31:0] POLY_CRC32 = 32'h04C11DB7;
  localparam logic [31:0] INIT_CRC32 = 32'hFFFFFFFF;

endpackage

// File: rtl/fcs_xor_engine_if.sv
// fcs_xor_engine_if: bundles the frame input stream, the result/status
// outputs and the serial FCS emit stream of fcs_xor_engine.
//   master : the surrounding datapath (payload source + modulator side)
//   slave  : the engine itself
// Handshakes: a beat transfers on a rising clock edge where valid and ready
// are both high; ready never depends combinationally on valid, and the
// producer holds its data stable while valid is high and ready is low.
interface fcs_xor_engine_if
  import fcs_pkg::*;
#(
  parameter int CRC_W = 32,
  parameter int DIN_W = 1,
  parameter int CNT_W = 16
);

  logic             start;      // abort/reload pulse, enters ACCUM
  logic             in_valid;   // payload beat valid
  logic             in_ready;   // high only in ACCUM
  logic [DIN_W-1:0] in_data;    // MSB is earliest bit in time
  logic             in_last;    // final beat of frame
  logic [CRC_W-1:0] val;        // CRC(data) ^ CRC(zeros)
  logic             done;       // one-cycle frame-complete pulse
  logic [CNT_W-1:0] frame_bits; // saturating bit count
  logic             fcs_valid;  // emit bit valid (EMIT state)
  logic             fcs_bit;    // current emit bit
  logic             fcs_ready;  // consumer accepts fcs_bit
  logic             busy;       // state != IDLE
  fcs_state_e       state;      // debug view of the engine FSM

  modport master (
    output start, in_valid, in_data, in_last, fcs_ready,
    input  in_ready, val, done, frame_bits, fcs_valid, fcs_bit, busy, state
  );

  modport slave (
    input  start, in_valid, in_data, in_last, fcs_ready,
    output in_ready, val, done, frame_bits, fcs_valid, fcs_bit, busy, state
  );

endinterface

// File: rtl/fcs_lfsr_step.sv
// fcs_lfsr_step: combinational DIN_W-bit unrolled CRC LFSR update.
//   state_i : current CRC register
//   data_i  : DIN_W input bits, data_i[DIN_W-1] applied first
//   state_o : register after all DIN_W single-bit steps
module fcs_lfsr_step #(
  parameter int          CRC_W = 32,
  parameter logic [31:0] POLY  = 32'h04C11DB7,
  parameter int          DIN_W = 1
) (
  input  logic [CRC_W-1:0] state_i,
  input  logic [DIN_W-1:0] data_i,
  output logic [CRC_W-1:0] state_o
);

  localparam logic [CRC_W-1:0] POLY_W = POLY[CRC_W-1:0];

  logic [CRC_W-1:0] s;

  always_comb begin
    s = state_i;
    for (int i = DIN_W - 1; i >= 0; i--) begin
      s = {s[CRC_W-2:0], 1'b0} ^ (POLY_W & {CRC_W{data_i[i] ^ s[CRC_W-1]}});
    end
    state_o = s;
  end

endmodule

// File: rtl/fcs_xor_engine.sv
// fcs_xor_engine: computes val = CRC(data) ^ CRC(equal-length zeros) over a
// framed stream, DIN_W bits per accepted beat, then (EMIT_EN=1) streams val
// out bit-serially for XORing onto the backscatter FCS field.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fcs_xor_engine_if.slave (start, input stream, val/done/
//              frame_bits/busy status, serial emit stream, debug state)
module fcs_xor_engine
  import fcs_pkg::*;
#(
  parameter int               CRC_W          = 32,
  parameter logic [31:0]      POLY           = POLY_CRC32,
  parameter logic [CRC_W-1:0] INIT           = {CRC_W{1'b1}},
  parameter int               DIN_W          = 1,
  parameter int               EMIT_EN        = 1,
  parameter int               EMIT_LSB_FIRST = 0,
  parameter int               CNT_W          = 16
) (
  input logic          clk,
  input logic          rst,
  fcs_xor_engine_if.slave bus
);

  localparam int             EC_W    = $clog2(CRC_W + 1);
  localparam logic [CNT_W:0] DIN_INC = (CNT_W + 1)'(DIN_W);

  fcs_state_e       state_q, state_d;
  logic [CRC_W-1:0] data_q, data_d, zero_q, zero_d;
  logic [CRC_W-1:0] data_nx, zero_nx;
  logic [CRC_W-1:0] shreg_q, shreg_d;
  logic [EC_W-1:0]  emit_cnt_q, emit_cnt_d;
  logic [CNT_W-1:0] frame_bits_q, frame_bits_d;
  logic [CNT_W:0]   cnt_sum;
  logic             done_q, done_d;

  // Data LFSR and a twin fed with zeros; their XOR cancels INIT's effect.
  fcs_lfsr_step #(.CRC_W(CRC_W), .POLY(POLY), .DIN_W(DIN_W)) u_step_data (
    .state_i(data_q), .data_i(bus.in_data), .state_o(data_nx)
  );
  fcs_lfsr_step #(.CRC_W(CRC_W), .POLY(POLY), .DIN_W(DIN_W)) u_step_zero (
    .state_i(zero_q), .data_i('0), .state_o(zero_nx)
  );

  // Extra carry bit detects wrap so the count sticks at all ones.
  assign cnt_sum = {1'b0, frame_bits_q} + DIN_INC;

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    zero_d       = zero_q;
    shreg_d      = shreg_q;
    emit_cnt_d   = emit_cnt_q;
    frame_bits_d = frame_bits_q;
    done_d       = 1'b0;
    if (bus.start) begin
      // Abort whatever is in flight; coincident handshakes are dropped.
      state_d      = ACCUM;
      data_d       = INIT;
      zero_d       = INIT;
      emit_cnt_d   = '0;
      frame_bits_d = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (bus.in_valid) begin
            data_d       = data_nx;
            zero_d       = zero_nx;
            frame_bits_d = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
            if (bus.in_last) begin
              done_d     = 1'b1;
              shreg_d    = data_nx ^ zero_nx;
              emit_cnt_d = EC_W'(CRC_W);
              state_d    = (EMIT_EN != 0) ? EMIT : IDLE;
            end
          end
        end
        EMIT: begin
          if (bus.fcs_ready) begin
            if (EMIT_LSB_FIRST != 0) shreg_d = {1'b0, shreg_q[CRC_W-1:1]};
            else                     shreg_d = {shreg_q[CRC_W-2:0], 1'b0};
            emit_cnt_d = emit_cnt_q - EC_W'(1);
            if (emit_cnt_q == EC_W'(1)) state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      data_q       <= INIT;
      zero_q       <= INIT;
      shreg_q      <= '0;
      emit_cnt_q   <= '0;
      frame_bits_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      zero_q       <= zero_d;
      shreg_q      <= shreg_d;
      emit_cnt_q   <= emit_cnt_d;
      frame_bits_q <= frame_bits_d;
      done_q       <= done_d;
    end
  end

  // All handshake outputs decode registered state only.
  assign bus.in_ready   = (state_q == ACCUM);
  assign bus.fcs_valid  = (state_q == EMIT);
  assign bus.fcs_bit    = (state_q == EMIT) &&
                          ((EMIT_LSB_FIRST != 0) ? shreg_q[0] : shreg_q[CRC_W-1]);
  assign bus.busy       = (state_q != IDLE);
  assign bus.val        = data_q ^ zero_q;
  assign bus.done       = done_q;
  assign bus.frame_bits = frame_bits_q;
  assign bus.state      = state_q;

endmodule
